// File: rtl/dac_dither_seq.sv
// Dither sequencer for the SPGD loop: steps the DAC through base+delta / base-delta pairs,
// holding each step for a settle time before opening an averaging window for the ADC averager.
module dac_dither_seq #(
  parameter int DAC_WIDTH = 14,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 ADC_CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [DAC_WIDTH-1:0] BASE_CODE,
  input  logic [DAC_WIDTH-1:0] DELTA,
  input  logic [CNT_WIDTH-1:0] SETTLE_CYCLES,
  input  logic [CNT_WIDTH-1:0] AVE_CYCLES,
  input  logic [CNT_WIDTH-1:0] NUM_PAIRS,
  output logic [DAC_WIDTH-1:0] DAC_CODE_OUT,
  output logic                 AVE_EN,
  output logic                 AVE_SIGN,
  output logic                 PAIR_DONE,
  output logic                 BUSY,
  output logic                 DONE
);

  typedef enum logic [2:0] {IDLE, SET_P, MEAS_P, SET_N, MEAS_N, FIN} state_t;

  // Two guard bits so that even a full-scale DELTA on a full-scale BASE cannot wrap.
  localparam int SW = DAC_WIDTH + 2;
  localparam logic signed [SW-1:0] MAX_C = {3'b000, {(DAC_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_C = {3'b111, {(DAC_WIDTH-1){1'b0}}};

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, pair_q, pair_d, pair_next;
  logic [CNT_WIDTH-1:0] s_lim_q, s_lim_d, a_lim_q, a_lim_d, npairs_q, npairs_d;
  logic [DAC_WIDTH-1:0] base_q, base_d, p_q, p_d, n_q, n_d, dac_q, dac_d;
  logic                 ave_en_q, ave_en_d, ave_sign_q, ave_sign_d;
  logic                 pair_done_q, pair_done_d, busy_q, busy_d, done_q, done_d;

  logic                 start_acc, cnt_last;
  logic signed [SW-1:0] base_x, delta_x, sum_p, sum_n;
  logic [DAC_WIDTH-1:0] p_code, n_code;

  // START is a single-cycle request, accepted only when the sequencer sits in IDLE;
  // any START seen in another state (including FIN) is dropped without side effects.
  assign start_acc = START && (state_q == IDLE);
  assign pair_next = pair_q + 1'b1;
  assign cnt_last  = ((state_q == SET_P) || (state_q == SET_N)) ? (cnt_q == s_lim_q)
                                                                : (cnt_q == a_lim_q);

  always_comb begin
    base_x = {{2{BASE_CODE[DAC_WIDTH-1]}}, BASE_CODE};
    delta_x = {2'b00, DELTA};
    sum_p = base_x + delta_x;
    sum_n = base_x - delta_x;
    if (sum_p > MAX_C)      p_code = {1'b0, {(DAC_WIDTH-1){1'b1}}};
    else if (sum_p < MIN_C) p_code = {1'b1, {(DAC_WIDTH-1){1'b0}}};
    else                    p_code = sum_p[DAC_WIDTH-1:0];
    if (sum_n > MAX_C)      n_code = {1'b0, {(DAC_WIDTH-1){1'b1}}};
    else if (sum_n < MIN_C) n_code = {1'b1, {(DAC_WIDTH-1){1'b0}}};
    else                    n_code = sum_n[DAC_WIDTH-1:0];
  end

  always_ff @(posedge ADC_CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = (NUM_PAIRS != '0) ? SET_P : FIN;
      SET_P:   if (cnt_last) state_d = MEAS_P;
      MEAS_P:  if (cnt_last) state_d = SET_N;
      SET_N:   if (cnt_last) state_d = MEAS_N;
      MEAS_N:  if (cnt_last) state_d = (pair_next == npairs_q) ? FIN : SET_P;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if ((state_d != state_q) || (state_q == IDLE) || (state_q == FIN)) cnt_d = '0;

    pair_d   = pair_q;
    base_d   = base_q;
    p_d      = p_q;
    n_d      = n_q;
    s_lim_d  = s_lim_q;
    a_lim_d  = a_lim_q;
    npairs_d = npairs_q;
    if (start_acc) begin
      pair_d   = '0;
      base_d   = BASE_CODE;
      p_d      = p_code;
      n_d      = n_code;
      s_lim_d  = (SETTLE_CYCLES == '0) ? '0 : SETTLE_CYCLES - 1'b1;
      a_lim_d  = (AVE_CYCLES == '0) ? '0 : AVE_CYCLES - 1'b1;
      npairs_d = NUM_PAIRS;
    end else if ((state_q == MEAS_N) && cnt_last) begin
      pair_d = pair_next;
    end

    // The DAC code moves only on state entry; IDLE tracks the live base code.
    dac_d = dac_q;
    if (state_q == IDLE)                             dac_d = (state_d == SET_P) ? p_code : BASE_CODE;
    else if (state_q == FIN)                         dac_d = base_q;
    else if ((state_d == SET_P) && (state_q != SET_P)) dac_d = p_q;
    else if ((state_d == SET_N) && (state_q != SET_N)) dac_d = n_q;

    ave_en_d    = (state_d == MEAS_P) || (state_d == MEAS_N);
    ave_sign_d  = (state_d == MEAS_N);
    busy_d      = (state_d == SET_P) || (state_d == MEAS_P) || (state_d == SET_N) || (state_d == MEAS_N);
    done_d      = (state_d == FIN);
    pair_done_d = (state_q == MEAS_N) && (state_d != MEAS_N);
  end

  always_ff @(posedge ADC_CLK) begin
    if (RESET) begin
      cnt_q       <= '0;
      pair_q      <= '0;
      base_q      <= '0;
      p_q         <= '0;
      n_q         <= '0;
      s_lim_q     <= '0;
      a_lim_q     <= '0;
      npairs_q    <= '0;
      dac_q       <= '0;
      ave_en_q    <= 1'b0;
      ave_sign_q  <= 1'b0;
      pair_done_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pair_q      <= pair_d;
      base_q      <= base_d;
      p_q         <= p_d;
      n_q         <= n_d;
      s_lim_q     <= s_lim_d;
      a_lim_q     <= a_lim_d;
      npairs_q    <= npairs_d;
      dac_q       <= dac_d;
      ave_en_q    <= ave_en_d;
      ave_sign_q  <= ave_sign_d;
      pair_done_q <= pair_done_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign DAC_CODE_OUT = dac_q;
  assign AVE_EN       = ave_en_q;
  assign AVE_SIGN     = ave_sign_q;
  assign PAIR_DONE    = pair_done_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;

endmodule

// File: tb/tb_dac_dither_seq.sv
// Bench for dac_dither_seq: a timeline model builds the expected per-cycle output trace of a
// whole sequence from the base/delta/settle/average/pair settings, and each cycle is compared.
module tb_dac_dither_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] base_code, delta;
  logic [15:0] settle_cycles, ave_cycles, num_pairs;
  logic [13:0] dac_out;
  logic        ave_en, ave_sign, pair_done, busy, done;

  int tests_run = 0;
  int tests_failed = 0;

  // Expected entry: {dac[13:0], ave_en, ave_sign, pair_done, busy, done}
  logic [18:0] exp_q[$];

  always #5 clk = ~clk;

  dac_dither_seq dut (
    .ADC_CLK(clk), .RESET(rst), .START(start), .BASE_CODE(base_code), .DELTA(delta),
    .SETTLE_CYCLES(settle_cycles), .AVE_CYCLES(ave_cycles), .NUM_PAIRS(num_pairs),
    .DAC_CODE_OUT(dac_out), .AVE_EN(ave_en), .AVE_SIGN(ave_sign), .PAIR_DONE(pair_done),
    .BUSY(busy), .DONE(done)
  );

  function automatic logic [13:0] sat(input int v);
    int c;
    c = (v > 8191) ? 8191 : ((v < -8192) ? -8192 : v);
    return c[13:0];
  endfunction

  // Cycle-by-cycle expectation starting the cycle after START, ending one cycle after FIN.
  task automatic build_trace(input int b, input int d, input int s, input int a, input int n);
    int se, ae;
    logic [13:0] bc, pc, nc;
    se = (s == 0) ? 1 : s;
    ae = (a == 0) ? 1 : a;
    bc = sat(b);
    pc = sat(b + d);
    nc = sat(b - d);
    exp_q.delete();
    if (n == 0) begin
      exp_q.push_back({bc, 5'b00001});
    end else begin
      for (int k = 0; k < n; k++) begin
        for (int i = 0; i < se; i++) exp_q.push_back({pc, 2'b00, (k > 0 && i == 0), 2'b10});
        for (int i = 0; i < ae; i++) exp_q.push_back({pc, 5'b10010});
        for (int i = 0; i < se; i++) exp_q.push_back({nc, 5'b00010});
        for (int i = 0; i < ae; i++) exp_q.push_back({nc, 5'b11010});
      end
      exp_q.push_back({nc, 5'b00101});
    end
    exp_q.push_back({bc, 5'b00000});
  endtask

  task automatic apply_start(input int b, input int d, input int s, input int a, input int n);
    @(negedge clk);
    base_code     = sat(b);
    delta         = d[13:0];
    settle_cycles = s[15:0];
    ave_cycles    = a[15:0];
    num_pairs     = n[15:0];
    start         = 1'b1;
  endtask

  // Runs one sequence; with disturb set, a second START plus new inputs arrive mid-run
  // and another START lands in the FIN cycle.
  task automatic run_seq(input string name, input int b, input int d, input int s,
                         input int a, input int n, input bit disturb);
    logic [18:0] want, got;
    int len;
    build_trace(b, d, s, a, n);
    len = exp_q.size();
    apply_start(b, d, s, a, n);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      got = {dac_out, ave_en, ave_sign, pair_done, busy, done};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL %s cyc %0d: got dac=%0d flags=%b, want dac=%0d flags=%b",
                 name, i + 1, $signed(got[18:5]), got[4:0], $signed(want[18:5]), want[4:0]);
      end
      start = disturb && ((i == 2) || want[0]);
      if (disturb && i == 2) begin
        base_code     = 14'($urandom);
        delta         = 14'($urandom);
        settle_cycles = 16'($urandom_range(0, 9));
        ave_cycles    = 16'($urandom_range(0, 9));
        num_pairs     = 16'($urandom_range(0, 9));
      end
      if (i == len - 1) base_code = sat(b);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    base_code = 14'd1234;
    delta = 14'd5;
    settle_cycles = 16'd1;
    ave_cycles = 16'd1;
    num_pairs = 16'd1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({dac_out, ave_en, ave_sign, pair_done, busy, done} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset: got dac=%0d flags=%b, want all zero", $signed(dac_out),
               {ave_en, ave_sign, pair_done, busy, done});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_track();
    logic [13:0] b;
    for (int k = 0; k < 4; k++) begin
      b = 14'($urandom);
      base_code = b;
      @(negedge clk);
      tests_run++;
      if (dac_out !== b || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_track: got dac=%0d busy=%b, want dac=%0d busy=0",
                 $signed(dac_out), busy, $signed(b));
      end
    end
  endtask

  task automatic test_basic();
    run_seq("basic", 100, 10, 3, 4, 1, 1'b0);
  endtask

  task automatic test_saturation();
    run_seq("sat_pos", 8190, 100, 2, 2, 1, 1'b0);
    run_seq("sat_neg", -8190, 100, 2, 2, 1, 1'b0);
    run_seq("sat_full", 8191, 16383, 1, 1, 1, 1'b0);
    run_seq("sat_full_neg", -8192, 16383, 1, 1, 1, 1'b0);
  endtask

  task automatic test_multi_pair();
    run_seq("multi_pair", -500, 37, 2, 2, 3, 1'b0);
    run_seq("many_pairs", 0, 1, 1, 1, 20, 1'b0);
  endtask

  task automatic test_zero_pairs();
    run_seq("zero_pairs", 321, 50, 3, 3, 0, 1'b0);
  endtask

  task automatic test_zero_cycles();
    run_seq("zero_cycles", 42, 7, 0, 0, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_seq("ignore_restart", 100, 10, 3, 4, 2, 1'b1);
    run_seq("ignore_fin_start", -77, 300, 0, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [18:0] want;
    build_trace(100, 10, 3, 4, 2);
    apply_start(100, 10, 3, 4, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      start = 1'b0;
      tests_run++;
      if ({dac_out, ave_en, ave_sign, pair_done, busy, done} !== want) begin
        tests_failed++;
        $display("FAIL reset_mid_pre cyc %0d: got dac=%0d ave=%b, want dac=%0d ave=%b",
                 i + 1, $signed(dac_out), ave_en, $signed(want[18:5]), want[4]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({dac_out, ave_en, ave_sign, pair_done, busy, done} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_zero: got dac=%0d flags=%b, want all zero", $signed(dac_out),
               {ave_en, ave_sign, pair_done, busy, done});
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({dac_out, ave_en, ave_sign, pair_done, busy, done} !== {14'd100, 5'b00000}) begin
      tests_failed++;
      $display("FAIL reset_mid_reload: got dac=%0d flags=%b, want dac=100 flags=00000",
               $signed(dac_out), {ave_en, ave_sign, pair_done, busy, done});
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || pair_done !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_mid_quiet cyc %0d: got done=%b pair_done=%b busy=%b, want 0",
                 i, done, pair_done, busy);
      end
    end
  endtask

  task automatic test_random();
    int b, d, s, a, n;
    for (int k = 0; k < 12; k++) begin
      b = $urandom_range(0, 16383) - 8192;
      d = $urandom_range(0, 16383);
      s = $urandom_range(0, 4);
      a = $urandom_range(0, 4);
      n = $urandom_range(0, 3);
      run_seq("random", b, d, s, a, n, k[0]);
    end
  endtask

  initial begin
    test_reset();
    test_idle_track();
    test_basic();
    test_saturation();
    test_multi_pair();
    test_zero_pairs();
    test_zero_cycles();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
